// File: rtl/apb_master_if.sv
// Command/response port and APB3 bus bundle for apb_master.
// The master modport is the requester side; the slave modport is the peripheral/agent side.
interface apb_master_if #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DWIDTH = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master.sv
// APB3 requester: one single-beat command at a time becomes a SETUP/ACCESS transfer,
// with a registered one-cycle response and an optional ACCESS-phase timeout.
module apb_master #(
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  localparam bit         TimeoutEn = (TIMEOUT != 0);
  localparam logic [7:0] TimeoutM1 = 8'(TIMEOUT - 1);

  state_e            r_state;
  logic [7:0]        r_wait_cnt;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [AWIDTH-1:0] r_paddr;
  logic [DWIDTH-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DWIDTH-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;

  logic w_timeout_hit;

  assign w_timeout_hit = TimeoutEn && (r_wait_cnt == TimeoutM1);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state       <= StIdle;
      r_wait_cnt    <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.cmd_valid) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
            r_psel   <= 1'b1;
            r_state  <= StSetup;
          end
        end
        StSetup: begin
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= StAccess;
        end
        StAccess: begin
          // PREADY wins over an expiring timeout in the same cycle.
          if (bus.PREADY) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= StIdle;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= bus.PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
          end else if (w_timeout_hit) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= StIdle;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
          end else if (r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == StIdle);
  assign bus.PSEL        = r_psel;
  assign bus.PENABLE     = r_penable;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a driver plays command source and APB slave,
// queuing expected responses for an independent response monitor.
module tb_apb_master;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 4;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            cyc;
  } exp_t;

  logic PCLK;
  logic PRESET;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  apb_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest queued expectation.
  always @(negedge PCLK) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_fields", {22'd0, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
            {22'd0, e.rdata, e.err, e.tmo});
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // waits >= TO means the slave never answers and the transfer times out.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input logic [DW-1:0] rd, input logic se);
    int   n;
    int   acc;
    bit   tmo;
    bit   rdy;
    exp_t e;
    tmo = (waits >= int'(TO));
    acc = tmo ? int'(TO) : waits + 1;
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    n = cyc;
    tick();
    e.rdata = (wr || tmo) ? '0 : rd;
    e.err   = tmo ? 1'b1 : se;
    e.tmo   = tmo;
    e.cyc   = n + 2 + acc;
    exp_q.push_back(e);
    // Junk command held valid during the transfer must be ignored.
    bus.cmd_write = ~wr;
    bus.cmd_addr  = ~a;
    bus.cmd_wdata = ~wd;
    chk("setup_bus", {16'd0, bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR,
                      bus.PWDATA}, {16'd0, 1'b0, 1'b1, 1'b0, wr, a, wd});
    // Slave responses during SETUP must be ignored.
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 8'hEE;
    tick();
    for (int i = 0; i < acc; i++) begin
      chk("access_bus", {16'd0, bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR,
                         bus.PWDATA}, {16'd0, 1'b0, 1'b1, 1'b1, wr, a, wd});
      rdy = !tmo && (i == waits);
      bus.PREADY  = rdy;
      bus.PSLVERR = rdy ? se : 1'b1;
      bus.PRDATA  = rdy ? rd : 8'h11;
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    chk("done_bus", {16'd0, bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR,
                     bus.PWDATA}, {16'd0, 1'b1, 1'b0, 1'b0, wr, a, wd});
    tick();
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {10'd0, bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA,
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
        {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    bus.PRDATA    = '0;
    tick();
    tick();
    PRESET = 1'b0;
    chk_zero("reset_state");
    tick();

    xfer(1'b1, 4'h2, 8'hA5, 0, 8'hFF, 1'b0);    // write, zero wait
    xfer(1'b0, 4'h6, 8'h00, 0, 8'h3C, 1'b0);    // read, zero wait
    chk("rsp_hold", {24'd0, bus.rsp_rdata}, 32'h3C);
    xfer(1'b0, 4'h9, 8'h00, 0, 8'h77, 1'b1);    // slave error
    xfer(1'b0, 4'h4, 8'h00, 3, 8'h5A, 1'b0);    // three wait states
    xfer(1'b1, 4'h1, 8'h42, 255, 8'h00, 1'b0);  // timeout
    xfer(1'b0, 4'hF, 8'h00, 3, 8'hC3, 1'b0);    // ready on last allowed cycle

    // Reset during wait states: no response, everything back to zero.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 4'h5;
    bus.cmd_wdata = 8'h99;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_access", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    chk_zero("reset_mid");
    tick();
    tick();
    xfer(1'b1, 4'h7, 8'h3C, 1, 8'h00, 1'b0);    // write after reset, one wait

    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
